// File: rtl/conv_engine_if.sv
// Result stream of the convolution engine: one window dot product per
// valid/ready handshake, tagged with its filter index and window position.
interface conv_engine_if;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [1:0]  out_filt;
    logic [7:0]  out_row;
    logic [7:0]  out_col;

    modport master (
        output out_valid, out_data, out_filt, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_filt, out_row, out_col,
        output out_ready
    );
endinterface

// File: rtl/conv_engine.sv
// Stride-1 4x4 convolution of a held image against four filters, one
// multiply-accumulate per cycle, results streamed over a valid/ready port.
module conv_engine #(
    parameter int IMG_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [7:0]          img_data_i [IMG_SIZE*IMG_SIZE],
    input  logic [7:0]          filters_i  [4][16],
    output logic                busy_o,
    output logic                done_o,
    conv_engine_if.master       res
);

    localparam int           OUT_SIZE = IMG_SIZE - 3;
    localparam int           NPIX     = IMG_SIZE * IMG_SIZE;
    localparam logic [7:0]   LAST_IDX = 8'(OUT_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  f_q, f_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  c_q, c_d;
    logic [3:0]  k_q, k_d;
    logic [19:0] acc_q, acc_d;
    logic [19:0] data_q, data_d;

    logic [15:0] pix_addr;
    logic [7:0]  pixel;
    logic [7:0]  tap;
    logic [15:0] product;
    logic        last_window;

    assign pix_addr = (16'(r_q) + 16'(k_q[3:2])) * 16'(IMG_SIZE)
                    + 16'(c_q) + 16'(k_q[1:0]);

    // Full-width address compare keeps every address bit meaningful; an
    // out-of-range address reads as zero instead of aliasing.
    always_comb begin
        pixel = 8'd0;
        for (int i = 0; i < NPIX; i++) begin
            if (pix_addr == 16'(i)) pixel = img_data_i[i];
        end
    end

    assign tap         = filters_i[f_q][k_q];
    assign product     = 16'(pixel) * 16'(tap);
    assign last_window = (f_q == 2'd3) && (r_q == LAST_IDX) && (c_q == LAST_IDX);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    f_d     = 2'd0;
                    r_d     = 8'd0;
                    c_d     = 8'd0;
                    k_d     = 4'd0;
                    acc_d   = 20'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + 20'(product);
                k_d   = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    data_d  = acc_d;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (res.out_ready) begin
                    k_d     = 4'd0;
                    acc_d   = 20'd0;
                    state_d = last_window ? DONE : MAC;
                    if (c_q == LAST_IDX) begin
                        c_d = 8'd0;
                        if (r_q == LAST_IDX) begin
                            r_d = 8'd0;
                            f_d = f_q + 2'd1;
                        end else begin
                            r_d = r_q + 8'd1;
                        end
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            f_q     <= 2'd0;
            r_q     <= 8'd0;
            c_q     <= 8'd0;
            k_q     <= 4'd0;
            acc_q   <= 20'd0;
            data_q  <= 20'd0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
        end
    end

    // Indices only move on a handshake, so they double as the output tags.
    assign res.out_valid = (state_q == OUT);
    assign res.out_data  = data_q;
    assign res.out_filt  = f_q;
    assign res.out_row   = r_q;
    assign res.out_col   = c_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);

endmodule

// File: doc/conv_engine.md
# conv_engine

Convolution stage directly downstream of the memory reader. Consumes the held image array (IMG_SIZE×IMG_SIZE bytes) and four 4×4 filters, and slides each filter over the image with stride 1. Emits one unsigned 20-bit dot product per window over a valid/ready stream, tagged with its filter, row and column indices. Uses one multiply-accumulate per cycle: 16 cycles per window.

## Interface
Parameters:
- IMG_SIZE, 16, image side length in pixels; must be ≥ 4 and ≤ 255.
- OUT_SIZE, IMG_SIZE-3, output side length; derived, do not override.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a full pass; sampled only in IDLE.
- img_data  input  8 × [0:IMG_SIZE*IMG_SIZE-1]  unsigned pixels, row-major; must be stable from start until done.
- filters  input  8 × [0:3][0:15]  unsigned kernels, row-major 4×4; must be stable from start until done.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  out_data/out_filt/out_row/out_col are valid.
- out_data  output  20  window dot product, unsigned.
- out_filt  output  2  filter index of current result.
- out_row, out_col  output  8 each  window top-left coordinate.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, MAC, OUT, DONE.
- IDLE:
  - On start, clear f, r, c, k and acc, then go to MAC.
  - Otherwise stay in IDLE.
- MAC:
  - Each cycle computes acc += img_data[(r+k/4)*IMG_SIZE + c + k%4] * filters[f][k], then k++.
  - When k==15, go to OUT on the next edge. The latched out_data equals the sum of all 16 products.
- OUT:
  - out_valid=1. out_data, out_filt, out_row and out_col are held stable until out_ready=1.
  - On handshake: clear k and acc, then advance the indices.
    - Order: c fastest, then r, then f. c wraps OUT_SIZE-1→0 with r++, and r wraps OUT_SIZE-1→0 with f++.
  - If the handshake is on the last window (f=3, r=c=OUT_SIZE-1), go to DONE; otherwise go to MAC.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Arithmetic rules:
  - Each product is 8×8 → 16 bits unsigned.
  - acc is 20 bits and cannot overflow: max is 16·255² = 1 040 400 < 2²⁰.
- start is ignored in MAC, OUT and DONE. It is not queued.
- out_ready is ignored when out_valid=0.
- Index arithmetic uses ≥ 16-bit internal address width. Out-of-range addresses are impossible by construction.

## Timing
- Reset values: out_valid=0, out_data=0, out_filt=0, out_row=0, out_col=0, busy=0, done=0, state=IDLE.
- rst asserted in any state (mid-pass included):
  - Next edge returns to IDLE with all outputs at reset values.
  - No done pulse. The partial pass is discarded.
- Start latency:
  - start sampled at edge 0 → MAC occupies cycles 1–16 → out_valid=1 from cycle 17.
  - busy rises at cycle 1.
- Throughput with out_ready held high: one result every 17 cycles (16 MAC + 1 OUT).
- Full pass for IMG_SIZE=16: 4·13·13 = 676 results, 11 492 cycles from first MAC to last handshake. done follows one cycle later.
- Backpressure: each stalled cycle in OUT adds one cycle. Output fields do not change while out_valid=1 and out_ready=0.
- Outputs are registered. No combinational path from out_ready to out_valid or out_data.

## Test plan
- All pixels 1, all filter taps 1, out_ready=1:
  - 676 results, each out_data=16.
  - Indices sequence (0,0,0),(0,0,1)…(3,12,12).
  - done exactly 1 cycle after the last handshake; busy low the cycle after done.
- All pixels 255, filter 2 taps 255, others 0:
  - Results for f=2 are 1 040 400; f=0,1,3 are 0.
  - No wrap or overflow.
- img_data[i]=i mod 256, filters[0] = identity-like (tap 0 = 1, others 0):
  - f=0 results equal img_data[r*16+c]. This checks window addressing at r=12, c=12 (value 204).
- out_ready low for 5 cycles on the 3rd result:
  - out_valid stays 1 and fields are unchanged for the whole stall.
  - Total pass length grows by exactly 5 cycles.
- rst pulsed during MAC of result 100:
  - Next cycle all outputs 0 and busy=0; no done.
  - A new start yields the full 676-result sequence from (0,0,0).
- start asserted repeatedly while busy: pass is unaffected, exactly one done, no second pass begins.
